// File: rtl/bk_sector_seq.sv
// bk_sector_seq: save-state sector sequencer between hps_io SD blocks and backup RAM
// Ports: clk_sys/RESET_n (sync, active-low) clock and reset; bk_ena/bk_load/bk_save/slot request side;
// sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_addr/sd_buff_wr hps_io sector side; add_bk/wren_bk backup-RAM side;
// bk_state busy, bk_loading load in progress, done/err one-cycle completion/timeout pulses.
module bk_sector_seq #(
  parameter int          SECT_BITS = 6,
  parameter int          SLOT_BITS = 2,
  parameter logic [23:0] TIMEOUT   = 24'd12000000
) (
  input  logic                   clk_sys,
  input  logic                   RESET_n,
  input  logic                   bk_ena,
  input  logic                   bk_load,
  input  logic                   bk_save,
  input  logic [SLOT_BITS-1:0]   slot,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic [8:0]             sd_buff_addr,
  input  logic                   sd_buff_wr,
  output logic [SECT_BITS+8:0]   add_bk,
  output logic                   wren_bk,
  output logic                   bk_state,
  output logic                   bk_loading,
  output logic                   done,
  output logic                   err
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  state_t r_state, w_state_n;
  logic [SECT_BITS-1:0] r_sect, w_sect_n;
  logic [SLOT_BITS-1:0] r_slot, w_slot_n;
  logic [23:0] r_cnt, w_cnt_n;
  logic r_rd, w_rd_n, r_wr, w_wr_n, r_busy, w_busy_n, r_loading, w_loading_n;
  logic r_done, w_done_n, r_err, w_err_n;
  logic r_ld_q, r_sv_q, r_ack_q;
  logic w_ld, w_sv, w_ld_rise, w_sv_rise, w_ack_rise, w_ack_fall;
  assign w_ld = bk_load & bk_ena;
  assign w_sv = bk_save & bk_ena;
  assign w_ld_rise = w_ld & ~r_ld_q;
  assign w_sv_rise = w_sv & ~r_sv_q;
  // ack history runs in every state, so an ack already high at accept never looks like a rising edge
  assign w_ack_rise = sd_ack & ~r_ack_q;
  assign w_ack_fall = ~sd_ack & r_ack_q;
  assign sd_lba = 32'({r_slot, r_sect});
  assign sd_rd = r_rd;
  assign sd_wr = r_wr;
  assign add_bk = {r_sect, sd_buff_addr};
  assign wren_bk = sd_buff_wr & sd_ack & r_loading;
  assign bk_state = r_busy;
  assign bk_loading = r_loading;
  assign done = r_done;
  assign err = r_err;
  always_comb begin
    w_state_n = r_state;
    w_sect_n = r_sect;
    w_slot_n = r_slot;
    w_cnt_n = r_cnt;
    w_rd_n = r_rd;
    w_wr_n = r_wr;
    w_busy_n = r_busy;
    w_loading_n = r_loading;
    w_done_n = 1'b0;
    w_err_n = 1'b0;
    case (r_state)
      IDLE: if (w_ld_rise | w_sv_rise) begin
        w_state_n = REQ;
        w_loading_n = w_ld_rise;
        w_rd_n = w_ld_rise;
        w_wr_n = ~w_ld_rise;
        w_busy_n = 1'b1;
        w_slot_n = slot;
        w_sect_n = '0;
        w_cnt_n = '0;
      end
      REQ: if (w_ack_rise) begin
        w_state_n = XFER;
        w_rd_n = 1'b0;
        w_wr_n = 1'b0;
        w_cnt_n = '0;
      end else if (r_cnt == TIMEOUT - 24'd1) begin
        w_state_n = IDLE;
        w_rd_n = 1'b0;
        w_wr_n = 1'b0;
        w_busy_n = 1'b0;
        w_loading_n = 1'b0;
        w_err_n = 1'b1;
      end else w_cnt_n = r_cnt + 24'd1;
      XFER: if (w_ack_fall) begin
        if (&r_sect) begin
          w_state_n = IDLE;
          w_busy_n = 1'b0;
          w_loading_n = 1'b0;
          w_done_n = 1'b1;
        end else begin
          w_state_n = REQ;
          w_sect_n = r_sect + 1'b1;
          w_rd_n = r_loading;
          w_wr_n = ~r_loading;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_state <= IDLE;
      r_sect <= '0;
      r_slot <= '0;
      r_cnt <= '0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_busy <= 1'b0;
      r_loading <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_ld_q <= 1'b0;
      r_sv_q <= 1'b0;
      r_ack_q <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sect <= w_sect_n;
      r_slot <= w_slot_n;
      r_cnt <= w_cnt_n;
      r_rd <= w_rd_n;
      r_wr <= w_wr_n;
      r_busy <= w_busy_n;
      r_loading <= w_loading_n;
      r_done <= w_done_n;
      r_err <= w_err_n;
      r_ld_q <= w_ld;
      r_sv_q <= w_sv;
      r_ack_q <= sd_ack;
    end
  end
endmodule

// File: tb/tb_bk_sector_seq.sv
// tb_bk_sector_seq: scoreboard bench for bk_sector_seq with an hps_io-like responder
module tb_bk_sector_seq;
  localparam int TO = 100;
  logic clk_sys = 1'b0;
  logic RESET_n, bk_ena, bk_load, bk_save, sd_ack, sd_buff_wr;
  logic [1:0] slot;
  logic [8:0] sd_buff_addr;
  logic [31:0] sd_lba;
  logic [14:0] add_bk;
  logic sd_rd, sd_wr, wren_bk, bk_state, bk_loading, done, err;
  int tests = 0, fails = 0;
  int unsigned cyc = 0, last_rise = 0;
  logic prev_req = 1'b0;
  logic [32:0] e;
  logic [32:0] exp_req[$];
  int exp_addr[$];
  bit exp_evt[$];
  bit resp_en;
  int ack_dly, ack_hold, nbytes, sl;
  logic found;

  bk_sector_seq #(.TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .bk_ena(bk_ena), .bk_load(bk_load), .bk_save(bk_save),
    .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr), .add_bk(add_bk), .wren_bk(wren_bk),
    .bk_state(bk_state), .bk_loading(bk_loading), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic bad(input string n);
    tests++;
    fails++;
    $display("FAIL %s: event occurred, none expected", n);
  endtask

  // reference: a whole operation is 64 sectors of slot*64+s; a load writes sector*512+byte for each byte served
  task automatic expect_op(input bit ld, input int s_l, input bit to);
    for (int s = 0; s < 64; s++) begin
      exp_req.push_back({ld, 32'(s_l * 64 + s)});
      if (ld && !to) for (int b = 0; b < nbytes; b++) exp_addr.push_back(s * 512 + b);
      if (to) break;
    end
    exp_evt.push_back(to);
  endtask

  task automatic wait_busy(input logic lvl, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk_sys);
      if (bk_state === lvl) return;
    end
    bad("busy_wait_timeout");
  endtask

  task automatic finish_op();
    wait_busy(1'b0, 60000);
    @(negedge clk_sys);
    chk("req_left", 64'(exp_req.size()), 64'd0);
    chk("addr_left", 64'(exp_addr.size()), 64'd0);
    chk("evt_left", 64'(exp_evt.size()), 64'd0);
    chk("busy_end", 64'(bk_state), 64'd0);
  endtask

  task automatic chk_zero(input string n);
    chk(n, {sd_lba, sd_rd, sd_wr, bk_state, bk_loading, done, err, wren_bk}, 64'd0);
  endtask

  // hps_io-like responder: ack after a delay, stream bytes on reads, hold ack on writes
  initial begin
    bit is_rd;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    sd_buff_addr = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (resp_en && (sd_rd || sd_wr) && !sd_ack) begin
        is_rd = sd_rd;
        repeat (ack_dly) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        if (is_rd) for (int i = 0; i < nbytes; i++) begin
          sd_buff_addr = 9'(i);
          sd_buff_wr = 1'b1;
          @(posedge clk_sys);
          #1;
        end else repeat (ack_hold) begin
          @(posedge clk_sys);
          #1;
        end
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a request, a RAM write or an end pulse
  always @(negedge clk_sys) begin
    cyc++;
    if (RESET_n) begin
      if ((sd_rd || sd_wr) && !prev_req) begin
        last_rise = cyc;
        if (exp_req.size() == 0) bad("unexpected_req");
        else begin
          e = exp_req.pop_front();
          chk("req", 64'({sd_rd, sd_wr, bk_loading, bk_state, sd_lba}), 64'({e[32], ~e[32], e[32], 1'b1, e[31:0]}));
        end
      end
      if (wren_bk) begin
        if (exp_addr.size() == 0) bad("unexpected_wren");
        else chk("add_bk", 64'(add_bk), 64'(exp_addr.pop_front()));
      end
      if (done || err) begin
        if (exp_evt.size() == 0) bad("unexpected_end");
        else chk("end_kind", 64'({done, err}), exp_evt.pop_front() ? 64'd1 : 64'd2);
        chk("end_idle", 64'({bk_state, bk_loading}), 64'd0);
        if (err) begin
          chk("timeout_lat", 64'(cyc - last_rise), 64'(TO));
          chk("err_drop", 64'(sd_rd | sd_wr), 64'd0);
        end
      end
    end
    prev_req = sd_rd | sd_wr;
  end

  initial begin
    RESET_n = 1'b0; bk_ena = 1'b0; bk_load = 1'b0; bk_save = 1'b0; slot = '0;
    resp_en = 1'b1; nbytes = 512; ack_dly = 5; ack_hold = 20;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_zero("reset_outputs");
    @(posedge clk_sys);
    #1 RESET_n = 1'b1; bk_ena = 1'b1;
    repeat (3) @(posedge clk_sys);
    // save to slot 2, bk_ena dropped mid-operation
    expect_op(1'b0, 2, 1'b0);
    #1 slot = 2'd2; bk_save = 1'b1;
    wait_busy(1'b1, 10);
    repeat (400) @(negedge clk_sys);
    bk_ena = 1'b0;
    repeat (100) @(negedge clk_sys);
    bk_save = 1'b0;
    bk_ena = 1'b1;
    finish_op();
    // full load, random slot and ack delay
    sl = $urandom_range(3, 0); ack_dly = $urandom_range(10, 1);
    expect_op(1'b1, sl, 1'b0);
    slot = 2'(sl); bk_load = 1'b1;
    wait_busy(1'b1, 10);
    bk_load = 1'b0;
    finish_op();
    // simultaneous load+save edges, extra save edge while busy, load level held past completion
    nbytes = 8; sl = $urandom_range(3, 0); ack_dly = $urandom_range(10, 1);
    expect_op(1'b1, sl, 1'b0);
    slot = 2'(sl); bk_load = 1'b1; bk_save = 1'b1;
    wait_busy(1'b1, 10);
    bk_save = 1'b0;
    slot = 2'(sl + 1);
    repeat (50) @(negedge clk_sys);
    bk_save = 1'b1;
    repeat (5) @(negedge clk_sys);
    bk_save = 1'b0;
    finish_op();
    repeat (50) @(negedge clk_sys);
    chk("no_retrigger", 64'(bk_state), 64'd0);
    bk_load = 1'b0;
    // save edge while disabled
    bk_ena = 1'b0;
    repeat (2) @(negedge clk_sys);
    bk_save = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk("ena_gate", 64'({bk_state, sd_wr}), 64'd0);
    bk_save = 1'b0;
    repeat (2) @(negedge clk_sys);
    bk_ena = 1'b1;
    // no ack: timeout abort
    resp_en = 1'b0; sl = $urandom_range(3, 0);
    expect_op(1'b1, sl, 1'b1);
    slot = 2'(sl); bk_load = 1'b1;
    wait_busy(1'b1, 10);
    bk_load = 1'b0;
    finish_op();
    resp_en = 1'b1;
    // reset during sector 10 of a save, then a fresh save
    sl = $urandom_range(3, 0); ack_dly = $urandom_range(10, 1); ack_hold = $urandom_range(20, 1);
    expect_op(1'b0, sl, 1'b0);
    slot = 2'(sl); bk_save = 1'b1;
    wait_busy(1'b1, 10);
    bk_save = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk_sys);
      found = sd_wr && sd_lba[5:0] == 6'd10;
    end
    if (!found) bad("sector10_wait");
    @(posedge clk_sys);
    #1 RESET_n = 1'b0;
    exp_req.delete();
    exp_evt.delete();
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk_zero("mid_reset_outputs");
    @(posedge clk_sys);
    #1 RESET_n = 1'b1;
    repeat (40) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("post_reset_idle", 64'(bk_state), 64'd0);
    sl = $urandom_range(3, 0);
    expect_op(1'b0, sl, 1'b0);
    slot = 2'(sl); bk_save = 1'b1;
    wait_busy(1'b1, 10);
    bk_save = 1'b0;
    finish_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
